// File: rtl/param_data_memory_if.sv
`default_nettype none
// ============================================================================
// Module   : param_data_memory_if
// Brief    : Request/response bus between the datapath and param_data_memory.
// Revision : 1.0 - initial release
// ============================================================================
interface param_data_memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      read_data_flag;
  logic                      write_data_flag;
  logic [DATA_WIDTH/8-1:0]   byte_enable;
  logic [ADDR_WIDTH-1:0]     address_of_data;
  logic [DATA_WIDTH-1:0]     data_to_write;
  logic                      rsp_valid;
  logic [DATA_WIDTH-1:0]     data_read_out;
  logic                      error;

  modport master (
    output req_valid, read_data_flag, write_data_flag, byte_enable,
           address_of_data, data_to_write,
    input  req_ready, rsp_valid, data_read_out, error
  );

  modport slave (
    input  req_valid, read_data_flag, write_data_flag, byte_enable,
           address_of_data, data_to_write,
    output req_ready, rsp_valid, data_read_out, error
  );
endinterface
`default_nettype wire

// File: rtl/param_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : param_data_memory
// Brief    : Handshaked, byte-masked data memory with programmable wait states.
// Revision : 1.0 - initial release
// ============================================================================
module param_data_memory #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 1,
  parameter int INIT_MODE   = 1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  param_data_memory_if.slave bus
);

  localparam int             c_BYTES = DATA_WIDTH / 8;
  localparam int             c_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0]     c_WAIT  = 4'(WAIT_STATES);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_cnt;
  logic [3:0]              w_cnt_nxt;
  logic                    w_accept;
  logic                    w_access;

  logic                    r_rd;
  logic                    r_wr;
  logic [c_BYTES-1:0]      r_be;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;

  logic                    r_rsp_valid;
  logic                    r_error;
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic [DATA_WIDTH-1:0]   w_init_word;
  logic [DATA_WIDTH-1:0]   w_rd_word;
  logic [DATA_WIDTH-1:0]   w_wr_word;

  // The array holds each word XOR its power-up value, so a plain all-zero
  // array realises either INIT_MODE without a per-word initialiser.
  logic [DATA_WIDTH-1:0]   r_mem [c_DEPTH] = '{default: '0};

  function automatic logic [DATA_WIDTH-1:0] init_word(input logic [ADDR_WIDTH-1:0] a);
    return (INIT_MODE == 1) ? DATA_WIDTH'(a) : '0;
  endfunction

  assign w_init_word = init_word(r_addr);
  assign w_rd_word   = r_mem[r_addr] ^ w_init_word;

  always_comb begin
    w_wr_word = w_rd_word;
    for (int k = 0; k < c_BYTES; k++) begin
      if (r_be[k]) w_wr_word[8*k +: 8] = r_wdata[8*k +: 8];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = BUSY;
          w_cnt_nxt   = c_WAIT;
        end
      end
      BUSY: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_access    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_be        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_error     <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rsp_valid <= w_access;
      r_error     <= w_access & r_rd & r_wr;
      if (w_accept) begin
        r_rd    <= bus.read_data_flag;
        r_wr    <= bus.write_data_flag;
        r_be    <= bus.byte_enable;
        r_addr  <= bus.address_of_data;
        r_wdata <= bus.data_to_write;
      end
      if (w_access && r_rd && !r_wr) r_rdata <= w_rd_word;
    end
  end

  // Array is deliberately outside the reset domain: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_access && r_wr && !r_rd) r_mem[r_addr] <= w_wr_word ^ w_init_word;
  end

  assign bus.req_ready     = (r_state == IDLE);
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.error         = r_error;
  assign bus.data_read_out = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_param_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_data_memory
// Brief    : Scoreboard bench for param_data_memory against an array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_data_memory;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int WS = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  param_data_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  param_data_memory #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .WAIT_STATES(WS),
    .INIT_MODE  (1)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model_mem [1 << AW];
  logic [DW-1:0] model_rd;
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present a request and hold it until accepted; acc is the accepting cycle.
  task automatic issue(input logic rd, input logic wr, input logic [DW/8-1:0] be,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit track, output int acc);
    int waitc = 0;
    exp_t e;
    @(negedge clk);
    bus.read_data_flag  = rd;
    bus.write_data_flag = wr;
    bus.byte_enable     = be;
    bus.address_of_data = a;
    bus.data_to_write   = d;
    bus.req_valid       = 1'b1;
    while (!bus.req_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    acc = cyc + 1;
    if (!bus.req_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      return;
    end
    if (track) begin
      e.err = 1'b0;
      if (rd && wr) begin
        e.err = 1'b1;
      end else if (rd) begin
        model_rd = model_mem[a];
      end else if (wr) begin
        for (int k = 0; k < DW/8; k++)
          if (be[k]) model_mem[a][8*k +: 8] = d[8*k +: 8];
      end
      e.data = model_rd;
      e.cyc  = acc + WS + 1;
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops one expectation per response strobe.
  int lowcnt   = 0;
  bit prev_rsp = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      lowcnt   = 0;
      prev_rsp = 1'b0;
    end else begin
      if (bus.rsp_valid) begin
        chk("rsp_one_cycle", 64'(prev_rsp), 64'd0);
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_error", 64'(bus.error), 64'(e.err));
          chk("rsp_data", 64'(bus.data_read_out), 64'(e.data));
          chk("rsp_latency", 64'(cyc), 64'(e.cyc));
          chk("ready_with_rsp", 64'(bus.req_ready), 64'd1);
        end
      end
      if (!bus.req_ready) begin
        lowcnt++;
      end else if (lowcnt != 0) begin
        chk("ready_low_cycles", 64'(lowcnt), 64'(WS + 1));
        lowcnt = 0;
      end
      prev_rsp = bus.rsp_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, acc;
    int sel;
    logic [AW-1:0] ra;
    for (int i = 0; i < (1 << AW); i++) model_mem[i] = DW'(i);
    model_rd            = '0;
    bus.req_valid       = 1'b0;
    bus.read_data_flag  = 1'b0;
    bus.write_data_flag = 1'b0;
    bus.byte_enable     = '0;
    bus.address_of_data = '0;
    bus.data_to_write   = '0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_error", 64'(bus.error), 64'd0);
    chk("reset_data", 64'(bus.data_read_out), 64'd0);

    issue(1'b1, 1'b0, 4'hF, 8'h05, 32'h0, 1'b1, acc);
    issue(1'b0, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 1'b1, acc);
    issue(1'b1, 1'b0, 4'hF, 8'h10, 32'h0, 1'b1, acc);
    issue(1'b0, 1'b1, 4'b0010, 8'h10, 32'h0000AA00, 1'b1, acc);
    issue(1'b1, 1'b0, 4'hF, 8'h10, 32'h0, 1'b1, acc);
    issue(1'b0, 1'b1, 4'b0000, 8'h11, 32'hCAFEF00D, 1'b1, acc);
    issue(1'b1, 1'b0, 4'hF, 8'h11, 32'h0, 1'b1, acc);
    issue(1'b1, 1'b1, 4'hF, 8'h20, 32'hFFFFFFFF, 1'b1, acc);
    issue(1'b1, 1'b0, 4'hF, 8'h20, 32'h0, 1'b1, acc);
    issue(1'b0, 1'b1, 4'hF, 8'hFF, 32'hA5A55A5A, 1'b1, acc);
    issue(1'b1, 1'b0, 4'hF, 8'hFF, 32'h0, 1'b1, acc);
    issue(1'b0, 1'b0, 4'hF, 8'h00, 32'h0, 1'b1, acc);

    issue(1'b1, 1'b0, 4'hF, 8'h01, 32'h0, 1'b1, a1);
    issue(1'b1, 1'b0, 4'hF, 8'h02, 32'h0, 1'b1, a2);
    chk("accept_spacing", 64'(a2 - a1), 64'(WS + 2));
    idle();
    drain();

    // Abort a write mid-flight; the monitor flags any stray response.
    issue(1'b0, 1'b1, 4'hF, 8'h30, 32'h12345678, 1'b0, acc);
    idle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_req_ready", 64'(bus.req_ready), 64'd1);
    chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("abort_error", 64'(bus.error), 64'd0);
    chk("abort_data", 64'(bus.data_read_out), 64'd0);
    model_rd = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (WS + 3) @(negedge clk);
    issue(1'b1, 1'b0, 4'hF, 8'h30, 32'h0, 1'b1, acc);
    idle();

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      ra  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      issue(sel < 4 || sel == 8, (sel >= 4 && sel < 8) || sel == 8,
            4'($urandom), ra, DW'($urandom), 1'b1, acc);
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
